// File: rtl/fwft_frame_serializer.sv
// Drains a first-word-fall-through FIFO and emits framed packets:
// HEADER, LEN, LEN payload words, XOR checksum (out_last) on a valid/ready stream.
module fwft_frame_serializer #(
    parameter int         AWIDTH      = 2,
    parameter int         DWIDTH      = 8,
    parameter int         MAX_PAYLOAD = 4,
    parameter int         TIMEOUT     = 8,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic              clk,
    input  logic              resn,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic [AWIDTH:0]   fifo_rd_data_count,
    output logic              fifo_read,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       frame_count
);

    localparam int CW = AWIDTH + 1;
    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    logic [2:0]        state_reg;
    logic [TW-1:0]     timer_reg;
    logic [LW-1:0]     len_reg;
    logic [LW-1:0]     remaining_reg;
    logic [DWIDTH-1:0] csum_reg;
    logic [15:0]       frame_count_reg;

    logic          count_full;
    logic          count_nz;
    logic          start;
    logic [LW-1:0] len_next;

    assign count_full = fifo_rd_data_count >= CW'(MAX_PAYLOAD);
    assign count_nz   = fifo_rd_data_count != '0;
    // A partial payload is flushed on the last timer cycle so the wait is exactly TIMEOUT cycles.
    assign start      = count_full || (count_nz && (timer_reg == TW'(TIMEOUT - 1)));
    assign len_next   = count_full ? LW'(MAX_PAYLOAD) : LW'(fifo_rd_data_count);

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            len_reg         <= '0;
            remaining_reg   <= '0;
            csum_reg        <= '0;
            frame_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg   <= len_next;
                        timer_reg <= '0;
                        csum_reg  <= '0;
                        state_reg <= ST_HDR;
                    end else if (!count_nz) begin
                        timer_reg <= '0;
                    end else if (timer_reg != TW'(TIMEOUT)) begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_HDR: begin
                    if (out_ready) state_reg <= ST_LEN;
                end
                ST_LEN: begin
                    if (out_ready) begin
                        csum_reg      <= DWIDTH'(len_reg);
                        remaining_reg <= len_reg;
                        state_reg     <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (out_ready) begin
                        csum_reg      <= csum_reg ^ fifo_data;
                        remaining_reg <= remaining_reg - LW'(1);
                        if (remaining_reg == LW'(1)) state_reg <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (out_ready) begin
                        frame_count_reg <= frame_count_reg + 16'd1;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Moore outputs; payload words pass straight through from the FIFO head.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        fifo_read = 1'b0;
        case (state_reg)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = DWIDTH'(HEADER);
            end
            ST_LEN: begin
                out_valid = 1'b1;
                out_data  = DWIDTH'(len_reg);
            end
            ST_PAY: begin
                out_valid = 1'b1;
                out_data  = fifo_data;
                fifo_read = out_ready;
            end
            ST_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_reg;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = state_reg != ST_IDLE;
    assign frame_count = frame_count_reg;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resn) assert (!(fifo_read && fifo_empty));
    end
`endif

endmodule

// File: doc/fwft_frame_serializer.md
Name: fwft_frame_serializer

Overview:
- Downstream consumer of the mini FWFT FIFO. It drains buffered words and emits them as framed packets on a valid/ready stream.
- Frame format: HEADER word, LEN word, LEN payload words, XOR checksum word.
- A frame starts when the FIFO holds a full payload, or when a partial payload has waited TIMEOUT cycles.
- It sits between the FIFO and the link/serial output stage.

Parameters:
- AWIDTH, 2: FIFO address width. Must match the upstream FIFO.
- DWIDTH, 8: word width. Must be ≥ 8.
- MAX_PAYLOAD, 4: maximum payload words per frame. Range 1..min(2**AWIDTH, 255).
- TIMEOUT, 8: idle cycles with a non-empty FIFO before a short frame is flushed. Range ≥ 1.
- HEADER, 8'hA5: frame start word, zero-extended to DWIDTH.

Ports:
- clk, input, 1: clock, rising edge.
- resn, input, 1: reset, asynchronous, active-low.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_data, input, DWIDTH: FIFO head word, valid whenever !fifo_empty.
- fifo_rd_data_count, input, AWIDTH+1: number of words in the FIFO.
- fifo_read, output, 1: pop strobe. Consumes fifo_data this cycle.
- out_data, output, DWIDTH: stream data.
- out_valid, output, 1: stream valid.
- out_ready, input, 1: stream ready.
- out_last, output, 1: high on the checksum word.
- busy, output, 1: high in any state other than IDLE.
- frame_count, output, 16: frames completed. Wraps modulo 2^16.

Behaviour:
- Reset: asynchronous, active-low, takes effect immediately on resn low.
  - State=IDLE; timer, len, remaining, csum and frame_count all 0.
  - All outputs read 0 immediately and while resn is low: out_valid, out_last, fifo_read, busy, out_data=0, frame_count=0.
  - A frame in progress is abandoned. Words already popped are lost; nothing else is popped.
- Transfer: a transfer occurs when out_valid && out_ready. All state advances happen only on transfers, except in IDLE.
- While out_ready is low, out_data, out_valid and out_last hold stable.
- State machine (registered state, Moore outputs):
  - IDLE:
    - out_valid=0 and out_data=0.
    - Timer: cleared when fifo_rd_data_count==0; otherwise increments, saturating at TIMEOUT.
    - Start condition, checked each edge: count ≥ MAX_PAYLOAD, OR (count ≠ 0 AND timer == TIMEOUT−1).
    - On start:
      - len ← min(count, MAX_PAYLOAD), latched once per frame.
      - timer ← 0, csum ← 0, go to HDR.
    - HDR is presented on the following cycle.
  - HDR: out_data=HEADER. On transfer, go to LEN.
  - LEN:
    - out_data = len zero-extended.
    - On transfer: csum ← len, remaining ← len, go to PAY.
  - PAY:
    - out_data = fifo_data (combinational pass-through).
    - fifo_read = out_ready (equivalently, transfer in this state).
    - On transfer: csum ← csum ^ fifo_data, remaining ← remaining − 1.
    - If remaining == 1, go to CSUM.
  - CSUM:
    - out_data = csum, out_last = 1.
    - On transfer: frame_count ← frame_count + 1, go to IDLE.
- fifo_read is asserted only in PAY.
  - len never exceeds the count at frame start, and this block is the only reader, so the FIFO is never read while empty.
  - fifo_empty is used only as an assertion check: fifo_read && fifo_empty is an error.
- Writes into the FIFO during a frame do not change len. Leftover words trigger the next frame through the normal IDLE evaluation.
- Back-to-back frames: after the CSUM transfer there is exactly one IDLE cycle (out_valid=0) before the next HDR.
- Minimum frame, len=1: HDR, LEN, 1 payload word, CSUM.
- Arithmetic:
  - csum is a DWIDTH-bit XOR.
  - remaining, timer and len are sized to their parameter ranges with no overflow.
  - frame_count wraps modulo 2^16.

Test Plan:
1. Full frame. DWIDTH=8, AWIDTH=2, MAX_PAYLOAD=4, out_ready=1. Write 11,22,33,44.
   - Response: stream A5,04,11,22,33,44,40; out_last only on 40; 4 fifo_read pulses; frame_count=1.
   - HDR appears one cycle after count reaches 4.
2. Timeout flush. Write a single 5A, then no further writes.
   - No output for 8 cycles after count becomes 1.
   - Then frame A5,01,5A,5B with out_last on 5B.
3. Backpressure. Same data as test 1, with out_ready toggled pseudo-randomly.
   - Response: identical word sequence; data, valid and last held stable while ready is low; fifo_read never asserts while out_ready=0.
4. Writes mid-frame. Write 4 words, start the frame, then write 2 more words (66,77) during PAY.
   - First frame LEN=04.
   - After one IDLE cycle and the 8-cycle timeout, a second frame A5,02,66,77,13.
   - frame_count=2.
5. Reset mid-payload. Assert resn low after 2 payload transfers.
   - In the same cycle: out_valid, fifo_read, busy and frame_count read 0.
   - After release: IDLE; the remaining FIFO words frame normally with LEN = current count.
6. Timer race. Write 2 words, then 2 more at timer=5.
   - Response: a single frame with LEN=04 is started by the count condition, with no short frame.
